eyeriss_pe_row: RTL and testbench
=================================

Name: eyeriss_pe_row

Overview:
- Row-stationary processing element for the Eyeriss accelerator: computes one 1D convolution row primitive.
- Holds FILT_LEN signed filter weights stationary and slides a FILT_LEN-wide window over a streamed ifmap row.
- Per window, adds an incoming partial sum from the PE below and emits one partial sum.
- Sits inside the PE array behind the top-level tt_um_eyeriss_madhav_malhotra I/O unpacking, which feeds its filter, ifmap and psum streams.

Parameters:
- DATA_W, 8: width of signed weight and ifmap words.
- PSUM_W, 16: width of signed partial sums and accumulator.
- FILT_LEN, 3: filter taps (window length); must be ≥2.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin a row; sampled only in IDLE.
- reuse_filt  in  1  sampled with start; 1 = skip filter load and keep the stored weights.
- row_len  in  8  ifmap pixels in the row; latched on start.
- filt_data  in  DATA_W  weight word, signed.
- filt_valid  in  1  weight word valid.
- filt_ready  out  1  PE accepts a weight word.
- ifmap_data  in  DATA_W  ifmap pixel, signed.
- ifmap_valid  in  1  ifmap pixel valid.
- ifmap_ready  out  1  PE accepts an ifmap pixel.
- psum_in_data  in  PSUM_W  incoming partial sum, signed.
- psum_in_valid  in  1  incoming partial sum valid.
- psum_in_ready  out  1  PE accepts an incoming partial sum.
- psum_out_data  out  PSUM_W  outgoing partial sum, signed.
- psum_out_valid  out  1  outgoing partial sum valid.
- psum_out_ready  in  1  downstream accepts the outgoing partial sum.
- busy  out  1  high whenever state != IDLE.
- done  out  1  one-cycle pulse at the end of a row.

Behaviour:
- Handshake: a transfer occurs on a cycle with valid&ready high. No ready depends combinationally on any valid. No output depends combinationally on any input.
- Reset (rst=1 at an edge), including mid-operation:
  - state=IDLE; all ready, valid, busy and done outputs 0; psum_out_data=0.
  - Weights, window, accumulator and counters cleared to 0. Any in-flight row is abandoned.
- IDLE:
  - start=1 with reuse_filt=0 -> LOAD_FILT.
  - start=1 with reuse_filt=1 -> FILL.
  - start while busy is ignored.
- LOAD_FILT: filt_ready=1. Weight k (k=0..FILT_LEN-1, in arrival order) is written per transfer. After the FILT_LEN-th transfer -> FILL.
- Short row: if latched row_len < FILT_LEN, leave LOAD_FILT (or IDLE, when reuse_filt=1) for DONE instead of FILL; no ifmap is consumed and no psum is produced.
- FILL: ifmap_ready=1. Shift FILT_LEN-1 pixels into window win[0..FILT_LEN-1]; each new pixel enters at win[FILT_LEN-1] and older pixels shift toward win[0]. Then -> WAIT_IN.
- WAIT_IN:
  - ifmap_ready = ~have_x; psum_in_ready = ~have_p.
  - Each stream is captured independently and sets its flag; either order and same-cycle capture are legal.
  - An ifmap capture shifts the window. A psum capture loads acc=psum_in_data.
  - When both flags are set -> MAC; flags clear.
- MAC: FILT_LEN cycles, k=0..FILT_LEN-1: acc += sext(w[k]*win[k]).
  - Product is 2*DATA_W bits, signed; it is sign-extended or truncated to PSUM_W.
  - Sum wraps modulo 2^PSUM_W; no saturation.
  - Then -> OUT.
- OUT: psum_out_valid=1, psum_out_data=acc, both held stable until the transfer. No ifmap or psum input is accepted while in OUT.
  - After the transfer, outputs produced so far = row_len-FILT_LEN+1 -> DONE; otherwise -> WAIT_IN.
- Latency: psum_out_valid rises FILT_LEN+1 cycles after the edge that completes the WAIT_IN capture.
- DONE: done=1 for one cycle, busy still 1 -> IDLE.
- Weights persist across rows until reset or the next LOAD_FILT.

Decomposition:
- Package eyeriss_pkg: DATA_W and PSUM_W defaults, PE state enum (IDLE, LOAD_FILT, FILL, WAIT_IN, MAC, OUT, DONE), a signed data typedef and a signed psum typedef.
- One sub-module: eyeriss_mac, a combinational signed DATA_W×DATA_W multiply plus PSUM_W wrap-add, shared by all MAC cycles.
- Tap and output counters sized $clog2(FILT_LEN) and 8 bits.

Test Plan:
- Basic row: filter [1,2,3], row_len=5, ifmap [1,2,3,4,5], psum_in [0,0,0] -> psum_out 14, 20, 26; done pulses once; busy then drops.
- Psum accumulation, reversed arrival: same filter and ifmap, psum_in [100,-100,5] presented before each ifmap -> 114, -80, 31.
- Backpressure: hold psum_out_ready=0 for 5 cycles on the first output -> data stays 14 and valid stays high; ifmap_ready=0 and psum_in_ready=0 throughout; then the sequence continues unchanged.
- Signed wrap: filter and ifmap all -128, row_len=3, psum_in 0 -> single output -16384 (49152 mod 2^16).
- Filter reuse and short row: start with reuse_filt=1, row_len=4, ifmap [2,2,2,2] -> 12, 12 with no filt_ready. Then row_len=2 -> no outputs, done 1 cycle after start.
- Reset mid-MAC: assert rst during MAC -> next cycle all outputs 0 and IDLE. A new row with filter [1,1,1], ifmap [1,1,1], psum_in 0 -> single output 3.

Source files
------------

// File: rtl/eyeriss_pkg.sv
// Shared types and defaults for the Eyeriss row-stationary PE.
// Holds the default word widths, the PE state encoding and the signed word types.
package eyeriss_pkg;

    localparam int DATA_W_DEFAULT = 8;
    localparam int PSUM_W_DEFAULT = 16;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        LOAD_FILT = 3'd1,
        FILL      = 3'd2,
        WAIT_IN   = 3'd3,
        MAC       = 3'd4,
        OUT       = 3'd5,
        DONE      = 3'd6
    } pe_state_e;

    typedef logic signed [DATA_W_DEFAULT-1:0] data_t;
    typedef logic signed [PSUM_W_DEFAULT-1:0] psum_t;

endpackage

// File: rtl/eyeriss_pe_row_if.sv
// Control and stream bundle between a row PE and whatever feeds it.
// The master modport belongs to the feeder; the slave modport belongs to the PE.
interface eyeriss_pe_row_if
    import eyeriss_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEFAULT,
    parameter int PSUM_W = PSUM_W_DEFAULT
);
    logic                     start;
    logic                     reuse_filt;
    logic [7:0]               row_len;
    logic signed [DATA_W-1:0] filt_data;
    logic                     filt_valid;
    logic                     filt_ready;
    logic signed [DATA_W-1:0] ifmap_data;
    logic                     ifmap_valid;
    logic                     ifmap_ready;
    logic signed [PSUM_W-1:0] psum_in_data;
    logic                     psum_in_valid;
    logic                     psum_in_ready;
    logic signed [PSUM_W-1:0] psum_out_data;
    logic                     psum_out_valid;
    logic                     psum_out_ready;
    logic                     busy;
    logic                     done;

    modport slave (
        input  start, reuse_filt, row_len,
        input  filt_data, filt_valid,
        input  ifmap_data, ifmap_valid,
        input  psum_in_data, psum_in_valid,
        input  psum_out_ready,
        output filt_ready, ifmap_ready, psum_in_ready,
        output psum_out_data, psum_out_valid,
        output busy, done
    );

    modport master (
        output start, reuse_filt, row_len,
        output filt_data, filt_valid,
        output ifmap_data, ifmap_valid,
        output psum_in_data, psum_in_valid,
        output psum_out_ready,
        input  filt_ready, ifmap_ready, psum_in_ready,
        input  psum_out_data, psum_out_valid,
        input  busy, done
    );

endinterface

// File: rtl/eyeriss_mac.sv
// Single shared multiply-accumulate: signed weight times signed pixel, product
// sign-extended or truncated to the psum width, then added with wrap-around.
module eyeriss_mac #(
    parameter int DATA_W = 8,
    parameter int PSUM_W = 16
) (
    input  logic signed [DATA_W-1:0] w_i,
    input  logic signed [DATA_W-1:0] x_i,
    input  logic signed [PSUM_W-1:0] acc_i,
    output logic signed [PSUM_W-1:0] sum_o
);

    logic signed [2*DATA_W-1:0] prod_s;

    assign prod_s = w_i * x_i;
    assign sum_o  = acc_i + PSUM_W'(prod_s);

endmodule

// File: rtl/eyeriss_pe_row.sv
// Row-stationary PE: keeps FILT_LEN weights resident, slides a window over an
// ifmap row and adds each window's dot product to a psum arriving from below.
module eyeriss_pe_row
    import eyeriss_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEFAULT,
    parameter int PSUM_W   = PSUM_W_DEFAULT,
    parameter int FILT_LEN = 3
) (
    input logic            clk,
    input logic            rst,
    eyeriss_pe_row_if.slave bus
);

    localparam int              KW          = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
    localparam logic [KW-1:0]   K_LAST      = KW'(FILT_LEN - 1);
    localparam logic [KW-1:0]   K_FILL_LAST = KW'(FILT_LEN - 2);
    localparam logic [8:0]      FILT_LEN_9  = 9'(FILT_LEN);

    pe_state_e                state_q, state_d;
    logic signed [DATA_W-1:0] w_q   [FILT_LEN];
    logic signed [DATA_W-1:0] w_d   [FILT_LEN];
    logic signed [DATA_W-1:0] win_q [FILT_LEN];
    logic signed [DATA_W-1:0] win_d [FILT_LEN];
    logic signed [PSUM_W-1:0] acc_q, acc_d;
    logic signed [PSUM_W-1:0] mac_sum_s;
    logic [KW-1:0]            k_q, k_d;
    logic [7:0]               out_cnt_q, out_cnt_d;
    logic [7:0]               row_len_q, row_len_d;
    logic                     have_x_q, have_x_d;
    logic                     have_p_q, have_p_d;
    logic                     filt_ready_q, filt_ready_d;
    logic                     ifmap_ready_q, ifmap_ready_d;
    logic                     psum_in_ready_q, psum_in_ready_d;
    logic                     psum_out_valid_q, psum_out_valid_d;
    logic                     busy_q, busy_d;
    logic                     done_q, done_d;

    logic filt_xfer_s, ifmap_xfer_s, psum_xfer_s, out_xfer_s;
    logic short_in_s, short_q_s, last_out_s;

    assign filt_xfer_s  = bus.filt_valid    & filt_ready_q;
    assign ifmap_xfer_s = bus.ifmap_valid   & ifmap_ready_q;
    assign psum_xfer_s  = bus.psum_in_valid & psum_in_ready_q;
    assign out_xfer_s   = psum_out_valid_q  & bus.psum_out_ready;

    // A row shorter than the filter yields no windows at all.
    assign short_in_s = ({1'b0, bus.row_len} < FILT_LEN_9);
    assign short_q_s  = ({1'b0, row_len_q}   < FILT_LEN_9);
    assign last_out_s = (({1'b0, out_cnt_q} + 9'd1) == ({1'b0, row_len_q} - FILT_LEN_9 + 9'd1));

    eyeriss_mac #(
        .DATA_W (DATA_W),
        .PSUM_W (PSUM_W)
    ) u_mac (
        .w_i   (w_q[k_q]),
        .x_i   (win_q[k_q]),
        .acc_i (acc_q),
        .sum_o (mac_sum_s)
    );

    // Next-state, datapath and registered-output decode.
    always_comb begin
        state_d   = state_q;
        w_d       = w_q;
        win_d     = win_q;
        acc_d     = acc_q;
        k_d       = k_q;
        out_cnt_d = out_cnt_q;
        row_len_d = row_len_q;
        have_x_d  = have_x_q;
        have_p_d  = have_p_q;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    row_len_d = bus.row_len;
                    k_d       = '0;
                    out_cnt_d = 8'd0;
                    have_x_d  = 1'b0;
                    have_p_d  = 1'b0;
                    if (bus.reuse_filt) begin
                        state_d = short_in_s ? DONE : FILL;
                    end else begin
                        state_d = LOAD_FILT;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            LOAD_FILT: begin
                if (filt_xfer_s) begin
                    w_d[k_q] = bus.filt_data;
                    if (k_q == K_LAST) begin
                        k_d     = '0;
                        state_d = short_q_s ? DONE : FILL;
                    end else begin
                        k_d = k_q + 1'b1;
                    end
                end else begin
                    state_d = LOAD_FILT;
                end
            end
            FILL: begin
                if (ifmap_xfer_s) begin
                    for (int i = 0; i < FILT_LEN - 1; i++) begin
                        win_d[i] = win_q[i+1];
                    end
                    win_d[FILT_LEN-1] = bus.ifmap_data;
                    if (k_q == K_FILL_LAST) begin
                        k_d     = '0;
                        state_d = WAIT_IN;
                    end else begin
                        k_d = k_q + 1'b1;
                    end
                end else begin
                    state_d = FILL;
                end
            end
            WAIT_IN: begin
                if (have_x_q && have_p_q) begin
                    have_x_d = 1'b0;
                    have_p_d = 1'b0;
                    state_d  = MAC;
                end else begin
                    if (ifmap_xfer_s) begin
                        for (int i = 0; i < FILT_LEN - 1; i++) begin
                            win_d[i] = win_q[i+1];
                        end
                        win_d[FILT_LEN-1] = bus.ifmap_data;
                        have_x_d = 1'b1;
                    end else begin
                        have_x_d = have_x_q;
                    end
                    if (psum_xfer_s) begin
                        acc_d    = bus.psum_in_data;
                        have_p_d = 1'b1;
                    end else begin
                        have_p_d = have_p_q;
                    end
                end
            end
            MAC: begin
                acc_d = mac_sum_s;
                if (k_q == K_LAST) begin
                    k_d     = '0;
                    state_d = OUT;
                end else begin
                    k_d = k_q + 1'b1;
                end
            end
            OUT: begin
                if (out_xfer_s) begin
                    out_cnt_d = out_cnt_q + 8'd1;
                    state_d   = last_out_s ? DONE : WAIT_IN;
                end else begin
                    state_d = OUT;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Handshake outputs are decoded from the next state so they come straight off flops.
        filt_ready_d     = (state_d == LOAD_FILT);
        ifmap_ready_d    = (state_d == FILL) || ((state_d == WAIT_IN) && !have_x_d);
        psum_in_ready_d  = (state_d == WAIT_IN) && !have_p_d;
        psum_out_valid_d = (state_d == OUT);
        busy_d           = (state_d != IDLE);
        done_d           = (state_d == DONE);
    end

    // State, datapath and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            for (int i = 0; i < FILT_LEN; i++) begin
                w_q[i]   <= '0;
                win_q[i] <= '0;
            end
            acc_q            <= '0;
            k_q              <= '0;
            out_cnt_q        <= 8'd0;
            row_len_q        <= 8'd0;
            have_x_q         <= 1'b0;
            have_p_q         <= 1'b0;
            filt_ready_q     <= 1'b0;
            ifmap_ready_q    <= 1'b0;
            psum_in_ready_q  <= 1'b0;
            psum_out_valid_q <= 1'b0;
            busy_q           <= 1'b0;
            done_q           <= 1'b0;
        end else begin
            state_q          <= state_d;
            w_q              <= w_d;
            win_q            <= win_d;
            acc_q            <= acc_d;
            k_q              <= k_d;
            out_cnt_q        <= out_cnt_d;
            row_len_q        <= row_len_d;
            have_x_q         <= have_x_d;
            have_p_q         <= have_p_d;
            filt_ready_q     <= filt_ready_d;
            ifmap_ready_q    <= ifmap_ready_d;
            psum_in_ready_q  <= psum_in_ready_d;
            psum_out_valid_q <= psum_out_valid_d;
            busy_q           <= busy_d;
            done_q           <= done_d;
        end
    end

    assign bus.filt_ready     = filt_ready_q;
    assign bus.ifmap_ready    = ifmap_ready_q;
    assign bus.psum_in_ready  = psum_in_ready_q;
    assign bus.psum_out_valid = psum_out_valid_q;
    assign bus.psum_out_data  = acc_q;
    assign bus.busy           = busy_q;
    assign bus.done           = done_q;

endmodule

// File: tb/tb_eyeriss_pe_row.sv
// Bench for eyeriss_pe_row: directed rows plus random rows, every psum compared
// against a dot-product model computed straight from the filter, row and psum lists.
module tb_eyeriss_pe_row;
    import eyeriss_pkg::*;

    localparam int F = 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    eyeriss_pe_row_if #(.DATA_W(8), .PSUM_W(16)) bus ();

    eyeriss_pe_row #(.DATA_W(8), .PSUM_W(16), .FILT_LEN(F)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_pass  = 0;
    int n_fail  = 0;
    int n_total = 0;
    int cyc     = 0;
    int filt_q[$];
    int ifm_q[$];
    int psm_q[$];
    int ref_w[F];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic idle_inputs();
        bus.start          = 1'b0;
        bus.reuse_filt     = 1'b0;
        bus.row_len        = 8'd0;
        bus.filt_data      = 8'sd0;
        bus.filt_valid     = 1'b0;
        bus.ifmap_data     = 8'sd0;
        bus.ifmap_valid    = 1'b0;
        bus.psum_in_data   = 16'sd0;
        bus.psum_in_valid  = 1'b0;
        bus.psum_out_ready = 1'b0;
    endtask

    // Window j output: psum_in[j] + sum_k w[k]*x[j+k], wrapped to 16 bits.
    function automatic logic signed [15:0] model_out(input int j);
        int s;
        s = psm_q[j];
        for (int k = 0; k < F; k++) s += ref_w[k] * ifm_q[j+k];
        return 16'(s);
    endfunction

    task automatic check_all_zero(input string tag);
        check({tag, " busy"},  32'(bus.busy), 32'd0);
        check({tag, " done"},  32'(bus.done), 32'd0);
        check({tag, " filt_ready"}, 32'(bus.filt_ready), 32'd0);
        check({tag, " ifmap_ready"}, 32'(bus.ifmap_ready), 32'd0);
        check({tag, " psum_in_ready"}, 32'(bus.psum_in_ready), 32'd0);
        check({tag, " psum_out_valid"}, 32'(bus.psum_out_valid), 32'd0);
        check({tag, " psum_out_data"}, 32'(bus.psum_out_data), 32'd0);
    endtask

    task automatic run_row(input bit reuse, input int rlen, input bit psum_first,
                           input int stall_n, input string tag);
        int nout, fi, ix, pi, oc, dones, done_edge, start_edge, last_cap, stalled;
        bit prev_v, saw_fr, fin, fx, xx, px, ox, ok_x;
        logic signed [15:0] exp_q[$];
        logic signed [15:0] od;
        nout = (rlen >= F) ? rlen - F + 1 : 0;
        if (!reuse) for (int k = 0; k < F; k++) ref_w[k] = filt_q[k];
        for (int j = 0; j < nout; j++) exp_q.push_back(model_out(j));
        fi = 0; ix = 0; pi = 0; oc = 0; dones = 0; done_edge = -1;
        last_cap = 0; stalled = 0; prev_v = 1'b0; saw_fr = 1'b0; fin = 1'b0;

        bus.start      = 1'b1;
        bus.reuse_filt = reuse;
        bus.row_len    = 8'(rlen);
        tick();
        start_edge = cyc;
        bus.start  = 1'b0;

        for (int c = 0; c < 3000 && !fin; c++) begin
            if (done_edge >= 0 && cyc == done_edge + 1) begin
                check({tag, " busy after done"}, 32'(bus.busy), 32'd0);
                check({tag, " done width"}, 32'(bus.done), 32'd0);
                fin = 1'b1;
            end else begin
                if (bus.done) begin
                    dones++;
                    if (done_edge < 0) done_edge = cyc;
                end
                if (bus.filt_ready && reuse) saw_fr = 1'b1;
                if (bus.psum_out_valid && !prev_v)
                    check({tag, " latency"}, 32'(cyc - last_cap), 32'(F + 1));
                prev_v = bus.psum_out_valid;

                if (bus.psum_out_valid && oc == 0 && stalled < stall_n) begin
                    check({tag, " stall data"}, 32'(bus.psum_out_data), 32'(exp_q[0]));
                    check({tag, " stall valid"}, 32'(bus.psum_out_valid), 32'd1);
                    check({tag, " stall ifmap_ready"}, 32'(bus.ifmap_ready), 32'd0);
                    check({tag, " stall psum_in_ready"}, 32'(bus.psum_in_ready), 32'd0);
                    bus.psum_out_ready = 1'b0;
                    stalled++;
                end else begin
                    bus.psum_out_ready = ($urandom_range(3) != 0);
                end

                bus.filt_valid = (fi < F) && ($urandom_range(3) != 0);
                bus.filt_data  = 8'((fi < F && !reuse) ? filt_q[fi] : 0);
                ok_x = (ix < rlen) && ($urandom_range(3) != 0);
                if (psum_first && ix >= F - 1 && pi <= ix - (F - 1)) ok_x = 1'b0;
                bus.ifmap_valid   = ok_x;
                bus.ifmap_data    = 8'((ix < rlen) ? ifm_q[ix] : 0);
                bus.psum_in_valid = (pi < nout) && ($urandom_range(3) != 0);
                bus.psum_in_data  = 16'((pi < nout) ? psm_q[pi] : 0);

                fx = bus.filt_valid && bus.filt_ready;
                xx = bus.ifmap_valid && bus.ifmap_ready;
                px = bus.psum_in_valid && bus.psum_in_ready;
                ox = bus.psum_out_valid && bus.psum_out_ready;
                od = bus.psum_out_data;
                tick();
                if (fx) fi++;
                if (xx) begin
                    if (ix >= F - 1) last_cap = cyc;
                    ix++;
                end
                if (px) begin
                    pi++;
                    last_cap = cyc;
                end
                if (ox) begin
                    if (oc < nout) check({tag, " psum_out"}, 32'(od), 32'(exp_q[oc]));
                    else check({tag, " extra output"}, 32'(oc), 32'(nout));
                    oc++;
                end
            end
        end
        idle_inputs();
        check({tag, " finished in budget"}, 32'(fin), 32'd1);
        check({tag, " output count"}, 32'(oc), 32'(nout));
        check({tag, " done pulses"}, 32'(dones), 32'd1);
        check({tag, " ifmap consumed"}, 32'(ix), 32'((nout > 0) ? rlen : 0));
        check({tag, " filt consumed"}, 32'(reuse ? 0 : fi), 32'(reuse ? 0 : F));
        if (reuse) check({tag, " no filt_ready"}, 32'(saw_fr), 32'd0);
        if (reuse && nout == 0) check({tag, " done latency"}, 32'(done_edge - start_edge), 32'd0);
    endtask

    task automatic push(input int which, input int val, input string tag);
        bit ok;
        ok = 1'b0;
        case (which)
            0:       begin bus.filt_valid    = 1'b1; bus.filt_data    = 8'(val);  end
            1:       begin bus.ifmap_valid   = 1'b1; bus.ifmap_data   = 8'(val);  end
            default: begin bus.psum_in_valid = 1'b1; bus.psum_in_data = 16'(val); end
        endcase
        for (int c = 0; c < 50 && !ok; c++) begin
            if ((which == 0 && bus.filt_ready) || (which == 1 && bus.ifmap_ready) ||
                (which == 2 && bus.psum_in_ready)) ok = 1'b1;
            tick();
        end
        bus.filt_valid = 1'b0; bus.ifmap_valid = 1'b0; bus.psum_in_valid = 1'b0;
        if (!ok) check({tag, " push accepted"}, 32'd0, 32'd1);
    endtask

    initial begin
        idle_inputs();
        rst = 1'b1;
        tick(); tick();
        check_all_zero("reset");
        rst = 1'b0;
        tick();

        filt_q = '{-128, -128, -128}; ifm_q = '{-128, -128, -128}; psm_q = '{0};
        run_row(1'b0, 3, 1'b0, 0, "wrap");

        filt_q = '{1, 2, 3}; ifm_q = '{1, 2, 3, 4, 5}; psm_q = '{0, 0, 0};
        run_row(1'b0, 5, 1'b0, 0, "basic");

        psm_q = '{100, -100, 5};
        run_row(1'b0, 5, 1'b1, 0, "psum_first");

        psm_q = '{0, 0, 0};
        run_row(1'b0, 5, 1'b0, 5, "backpressure");

        ifm_q = '{2, 2, 2, 2}; psm_q = '{0, 0};
        run_row(1'b1, 4, 1'b0, 0, "reuse");

        ifm_q = '{7, 7}; psm_q.delete();
        run_row(1'b1, 2, 1'b0, 0, "short");

        bus.start = 1'b1; bus.reuse_filt = 1'b0; bus.row_len = 8'd5;
        tick();
        bus.start = 1'b0;
        push(0, 1, "rm f0"); push(0, 2, "rm f1"); push(0, 3, "rm f2");
        push(1, 1, "rm x0"); push(1, 2, "rm x1");
        push(2, 0, "rm p0"); push(1, 3, "rm x2");
        tick(); tick();
        check("mid-MAC busy", 32'(bus.busy), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_all_zero("mid-MAC reset");

        filt_q = '{1, 1, 1}; ifm_q = '{1, 1, 1}; psm_q = '{0};
        run_row(1'b0, 3, 1'b0, 0, "after reset");

        for (int r = 0; r < 6; r++) begin
            int rl;
            bit ru;
            rl = $urandom_range(9, 2);
            ru = $urandom_range(1);
            filt_q.delete(); ifm_q.delete(); psm_q.delete();
            for (int k = 0; k < F; k++) filt_q.push_back(int'($urandom_range(255)) - 128);
            for (int i = 0; i < rl; i++) ifm_q.push_back(int'($urandom_range(255)) - 128);
            for (int i = 0; i < rl; i++) psm_q.push_back(int'($urandom_range(65535)) - 32768);
            run_row(ru, rl, r[0], 0, "random");
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
